// File: rtl/round_key_store.sv
// Round-key store: captures direct/inverse round keys from the scheduler and replays them
// ascending (encrypt) or descending (decrypt). Optional macro KEY_STORE_ZEROIZE_EN clears storage and rk_data.
module round_key_store #(
    parameter int MAX_ROUND_KEYS = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_start,
    input  logic [1:0]   key_length,
    input  logic         key_valid_in,
    input  logic [127:0] round_key_in,
    input  logic [127:0] inv_round_key_in,
    output logic         keys_ready,
    input  logic         rd_start,
    input  logic         rd_decrypt,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         rk_last
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY,
        READ
    } state_t;

    state_t       state;
    logic [3:0]   nr;
    logic [3:0]   wr_ptr;
    logic         decrypt;

    // Byte 0 of each key ([0:7] in FIPS numbering) sits in bits [127:120].
    logic [127:0] dir_mem [MAX_ROUND_KEYS];
    logic [127:0] inv_mem [MAX_ROUND_KEYS];

    logic         write_en;
    logic         start_read;
    logic         advance;
    logic         finish_read;
    logic         fetch_en;
    logic         fetch_dec;
    logic [3:0]   first_idx;
    logic [3:0]   next_idx;
    logic [3:0]   fetch_idx;
    logic [127:0] fetch_word;

    function automatic logic [3:0] decode_nr(input logic [1:0] len);
        case (len)
            2'b01:   decode_nr = 4'd12;
            2'b10:   decode_nr = 4'd14;
            default: decode_nr = 4'd10;
        endcase
    endfunction

    // rst and load_start outrank every other event, so all enables are qualified by them here.
    always_comb begin
        write_en    = !rst && !load_start && (state == LOAD) && key_valid_in && (wr_ptr <= nr);
        start_read  = !rst && !load_start && (state == READY) && rd_start;
        advance     = !rst && !load_start && (state == READ) && rk_valid && rk_ready && !rk_last;
        finish_read = !rst && !load_start && (state == READ) && rk_valid && rk_ready && rk_last;
        first_idx   = rd_decrypt ? nr : 4'd0;
        next_idx    = decrypt ? (rk_index - 4'd1) : (rk_index + 4'd1);
        fetch_idx   = start_read ? first_idx : next_idx;
        fetch_dec   = start_read ? rd_decrypt : decrypt;
        fetch_en    = start_read || advance;
        fetch_word  = fetch_dec ? inv_mem[fetch_idx] : dir_mem[fetch_idx];
    end

    always_ff @(posedge clk) begin
`ifdef KEY_STORE_ZEROIZE_EN
        if (rst || load_start) begin
            for (int i = 0; i < MAX_ROUND_KEYS; i++) begin
                dir_mem[i] <= '0;
                inv_mem[i] <= '0;
            end
        end else
`endif
        if (write_en) begin
            dir_mem[wr_ptr] <= round_key_in;
            inv_mem[wr_ptr] <= inv_round_key_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            nr         <= 4'd10;
            wr_ptr     <= 4'd0;
            decrypt    <= 1'b0;
            keys_ready <= 1'b0;
            rk_valid   <= 1'b0;
            rk_last    <= 1'b0;
            rk_index   <= 4'd0;
        end else if (load_start) begin
            // The key_valid_in beat coinciding with load_start is dropped by write_en.
            state      <= LOAD;
            nr         <= decode_nr(key_length);
            wr_ptr     <= 4'd0;
            keys_ready <= 1'b0;
            rk_valid   <= 1'b0;
            rk_last    <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (write_en) begin
                        wr_ptr <= wr_ptr + 4'd1;
                        if (wr_ptr == nr) begin
                            state      <= READY;
                            keys_ready <= 1'b1;
                        end
                    end
                end
                READY: begin
                    if (start_read) begin
                        state    <= READ;
                        decrypt  <= rd_decrypt;
                        rk_valid <= 1'b1;
                        rk_index <= first_idx;
                        rk_last  <= 1'b0;
                    end
                end
                READ: begin
                    if (finish_read) begin
                        state    <= READY;
                        rk_valid <= 1'b0;
                        rk_last  <= 1'b0;
                    end else if (advance) begin
                        rk_index <= next_idx;
                        rk_last  <= decrypt ? (next_idx == 4'd0) : (next_idx == nr);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // rk_data only changes when a new key is presented, so it holds during back-pressure.
    always_ff @(posedge clk) begin
`ifdef KEY_STORE_ZEROIZE_EN
        if (rst || load_start || finish_read) begin
            rk_data <= '0;
        end else if (fetch_en) begin
            rk_data <= fetch_word;
        end
`else
        if (fetch_en) begin
            rk_data <= fetch_word;
        end
`endif
    end

endmodule
